can_tx_priority: RTL and testbench

- Transmit-request priority queue for the CAN controller, placed between the host request interface and the CAN bit-level transmitter.
- It holds the frame currently offered for transmission in a transmit register (tx_reg).
- It keeps up to N further pending frames in a buffer.
- The frame in tx_reg is always the lowest-ID (highest CAN priority) frame known, including by preemption.

---
 rtl/can_tx_priority.sv | 156 +++++++++++++++
 tb/tb_can_tx_priority.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_priority.sv
// CAN transmit-request priority queue: tx_reg always holds the lowest-id known frame,
// with up to N further frames pending in a slot buffer.
module can_tx_priority #(
  parameter int unsigned N = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [10:0] req_id,
  input  logic [3:0]  req_dlc,
  input  logic [7:0]  req_data [8],
  input  logic        re,
  output logic        start_tx,
  output logic [10:0] tx_id,
  output logic [3:0]  tx_dlc,
  output logic [7:0]  tx_data [8],
  output logic        full,
  output logic        empty
);

  localparam int unsigned ID_W  = 11;
  localparam int unsigned DLC_W = 4;
  localparam int unsigned BYTES = 8;
  localparam int unsigned IW    = (N > 1) ? $clog2(N) : 1;

  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [DLC_W-1:0]      dlc;
    logic [BYTES-1:0][7:0] data;
  } frame_t;

  frame_t         tx_q, tx_d;
  logic           tx_valid_q, tx_valid_d;
  frame_t         slot_q [N];
  frame_t         slot_d [N];
  logic [N-1:0]   slot_valid_q, slot_valid_d;
  logic           full_q, empty_q;

  frame_t         req_frame;
  logic           best_valid;
  logic [IW-1:0]  best_idx;
  logic [ID_W-1:0] best_id;
  logic           free_found;
  logic [IW-1:0]  free_idx;
  logic           swap_found;
  logic [IW-1:0]  swap_idx;

  // Pack the request into a frame
  always_comb begin
    req_frame.id  = req_id;
    req_frame.dlc = req_dlc;
    req_frame.data = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      req_frame.data[b] = req_data[b];
    end
  end

  // Lowest-id valid slot (lowest index on ties), lowest free slot, and lowest slot
  // that is free once the best entry has been moved out.
  always_comb begin
    best_valid = 1'b0;
    best_idx   = '0;
    best_id    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (slot_valid_q[i] && (!best_valid || slot_q[i].id < best_id)) begin
        best_valid = 1'b1;
        best_idx   = IW'(i);
        best_id    = slot_q[i].id;
      end
      if (!free_found && !slot_valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
    swap_found = 1'b0;
    swap_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!swap_found && (!slot_valid_q[i] || (best_valid && IW'(i) == best_idx))) begin
        swap_found = 1'b1;
        swap_idx   = IW'(i);
      end
    end
  end

  // Next-state selection for tx_reg and buffer
  always_comb begin
    tx_d         = tx_q;
    tx_valid_d   = tx_valid_q;
    slot_d       = slot_q;
    slot_valid_d = slot_valid_q;
    if (re && tx_valid_q) begin
      // Retire current frame; the request beats buffer entries on equal ids
      if (we && !(best_valid && best_id < req_frame.id)) begin
        tx_d = req_frame;
      end else if (best_valid) begin
        tx_d = slot_q[best_idx];
        slot_valid_d[best_idx] = 1'b0;
        if (we && swap_found) begin
          slot_d[swap_idx]       = req_frame;
          slot_valid_d[swap_idx] = 1'b1;
        end
      end else begin
        tx_valid_d = 1'b0;
        tx_d       = '0;
      end
    end else if (we) begin
      if (!tx_valid_q) begin
        tx_d       = req_frame;
        tx_valid_d = 1'b1;
      end else if (free_found) begin
        if (req_frame.id < tx_q.id) begin
          tx_d             = req_frame;
          slot_d[free_idx] = tx_q;
        end else begin
          slot_d[free_idx] = req_frame;
        end
        slot_valid_d[free_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q         <= '0;
      tx_valid_q   <= 1'b0;
      slot_valid_q <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        slot_q[i] <= '0;
      end
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      tx_q         <= tx_d;
      tx_valid_q   <= tx_valid_d;
      slot_q       <= slot_d;
      slot_valid_q <= slot_valid_d;
      full_q       <= &slot_valid_d;
      empty_q      <= !tx_valid_d && (slot_valid_d == '0);
    end
  end

  assign start_tx = tx_valid_q;
  assign tx_id    = tx_q.id;
  assign tx_dlc   = tx_q.dlc;
  assign full     = full_q;
  assign empty    = empty_q;

  always_comb begin
    for (int unsigned b = 0; b < BYTES; b++) begin
      tx_data[b] = tx_q.data[b];
    end
  end

endmodule

// File: tb/tb_can_tx_priority.sv
// Bench for can_tx_priority: directed plan steps plus random traffic, each cycle
// compared against a slot-level behavioural model of the queue.
module tb_can_tx_priority;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic        re;
  logic [10:0] req_id;
  logic [3:0]  req_dlc;
  logic [7:0]  req_data [8];
  logic        start_tx;
  logic [10:0] tx_id;
  logic [3:0]  tx_dlc;
  logic [7:0]  tx_data [8];
  logic        full;
  logic        empty;

  always #5 clk = ~clk;

  can_tx_priority #(.N(N)) dut (
    .clk(clk), .rst(rst), .we(we), .req_id(req_id), .req_dlc(req_dlc),
    .req_data(req_data), .re(re), .start_tx(start_tx), .tx_id(tx_id),
    .tx_dlc(tx_dlc), .tx_data(tx_data), .full(full), .empty(empty)
  );

  typedef struct {
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
  } fr_t;

  fr_t m_tx;
  bit  m_txv;
  fr_t m_s [N];
  bit  m_sv [N];
  int  n_total = 0;
  int  n_pass  = 0;

  function automatic logic [63:0] mkdata(input logic [10:0] id);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(i) + id[7:0];
    return d;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < int'(N); i++) if (m_sv[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    m_txv = 1'b0;
    m_tx  = '{id: 11'd0, dlc: 4'd0, data: 64'd0};
    for (int i = 0; i < int'(N); i++) m_sv[i] = 1'b0;
  endtask

  task automatic model_put(input fr_t f);
    for (int i = 0; i < int'(N); i++) begin
      if (!m_sv[i]) begin
        m_s[i]  = f;
        m_sv[i] = 1'b1;
        return;
      end
    end
  endtask

  task automatic model_apply(input bit w, input bit r, input fr_t q);
    int b = -1;
    for (int i = 0; i < int'(N); i++)
      if (m_sv[i] && (b < 0 || m_s[i].id < m_s[b].id)) b = i;
    if (r && m_txv) begin
      if (w && (b < 0 || q.id <= m_s[b].id)) begin
        m_tx = q;
      end else begin
        if (b >= 0) begin
          m_tx    = m_s[b];
          m_sv[b] = 1'b0;
        end else begin
          m_txv = 1'b0;
          m_tx  = '{id: 11'd0, dlc: 4'd0, data: 64'd0};
        end
        if (w) model_put(q);
      end
    end else if (w) begin
      if (!m_txv) begin
        m_tx  = q;
        m_txv = 1'b1;
      end else if (m_count() < int'(N)) begin
        if (q.id < m_tx.id) begin
          model_put(m_tx);
          m_tx = q;
        end else begin
          model_put(q);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string ctx);
    logic [63:0] got;
    for (int b = 0; b < 8; b++) got[b*8 +: 8] = tx_data[b];
    chk({ctx, ".start_tx"}, 64'(start_tx), 64'(m_txv));
    chk({ctx, ".tx_id"},    64'(tx_id),    64'(m_tx.id));
    chk({ctx, ".tx_dlc"},   64'(tx_dlc),   64'(m_tx.dlc));
    chk({ctx, ".tx_data"},  got,           m_tx.data);
    chk({ctx, ".full"},     64'(full),     64'(m_count() == int'(N)));
    chk({ctx, ".empty"},    64'(empty),    64'(!m_txv && m_count() == 0));
  endtask

  task automatic step(input string ctx, input bit w, input bit r, input logic [10:0] id,
                      input logic [3:0] dlc, input logic [63:0] data);
    fr_t q;
    @(negedge clk);
    we = w; re = r; req_id = id; req_dlc = dlc;
    for (int b = 0; b < 8; b++) req_data[b] = data[b*8 +: 8];
    q = '{id: id, dlc: dlc, data: data};
    model_apply(w, r, q);
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic wr(input string ctx, input logic [10:0] id);
    step(ctx, 1'b1, 1'b0, id, id[3:0], mkdata(id));
  endtask

  task automatic done(input string ctx);
    step(ctx, 1'b0, 1'b1, 11'd0, 4'd0, 64'd0);
  endtask

  task automatic idle(input string ctx);
    step(ctx, 1'b0, 1'b0, 11'd0, 4'd0, 64'd0);
  endtask

  task automatic do_reset(input string ctx);
    @(negedge clk);
    rst = 1'b1; we = 1'b0; re = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all(ctx);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; req_id = '0; req_dlc = '0;
    for (int b = 0; b < 8; b++) req_data[b] = '0;
    model_reset();

    // Reset and idle
    do_reset("reset");
    idle("idle1");
    idle("idle2");
    chk("reset.start_tx_const", 64'(start_tx), 64'd0);
    chk("reset.empty_const",    64'(empty),    64'd1);
    chk("reset.full_const",     64'(full),     64'd0);
    chk("reset.tx_id_const",    64'(tx_id),    64'd0);

    // Normal queuing
    wr("norm.w300", 11'd300);
    wr("norm.w500", 11'd500);
    chk("norm.tx_id_300", 64'(tx_id), 64'd300);
    done("norm.re1");
    chk("norm.tx_id_500", 64'(tx_id), 64'd500);
    chk("norm.byte3", 64'(tx_data[3]), 64'(8'hF7));
    done("norm.re2");
    chk("norm.empty", 64'(empty), 64'd1);

    // Preemption
    wr("pre.w700", 11'd700);
    wr("pre.w200", 11'd200);
    chk("pre.tx_id_200", 64'(tx_id), 64'd200);
    done("pre.re1");
    chk("pre.tx_id_700", 64'(tx_id), 64'd700);
    done("pre.re2");

    // Full buffer, drop and drain order
    wr("full.w400", 11'd400);
    wr("full.w450", 11'd450);
    wr("full.w600", 11'd600);
    wr("full.w100", 11'd100);
    chk("full.tx_id_100", 64'(tx_id), 64'd100);
    wr("full.w50", 11'd50);
    chk("full.full_set", 64'(full), 64'd1);
    wr("full.w10_drop", 11'd10);
    chk("full.tx_id_50", 64'(tx_id), 64'd50);
    done("full.re1");
    chk("full.tx_id_after1", 64'(tx_id), 64'd100);
    chk("full.full_clr", 64'(full), 64'd0);
    done("full.re2");
    done("full.re3");
    done("full.re4");
    chk("full.tx_id_last", 64'(tx_id), 64'd600);
    done("full.re5");
    chk("full.empty", 64'(empty), 64'd1);

    // Equal ids never preempt
    step("eq.first",  1'b1, 1'b0, 11'd300, 4'd2, mkdata(11'd300));
    step("eq.second", 1'b1, 1'b0, 11'd300, 4'd7, ~mkdata(11'd300));
    chk("eq.dlc_first", 64'(tx_dlc), 64'd2);
    done("eq.re1");
    chk("eq.dlc_second", 64'(tx_dlc), 64'd7);
    done("eq.re2");

    // Simultaneous write and done
    wr("sim.w300", 11'd300);
    wr("sim.w500", 11'd500);
    step("sim.we_re", 1'b1, 1'b1, 11'd400, 4'd4, mkdata(11'd400));
    chk("sim.tx_id_400", 64'(tx_id), 64'd400);
    done("sim.re1");
    done("sim.re2");
    wr("simf.w300", 11'd300);
    wr("simf.w500", 11'd500);
    wr("simf.w510", 11'd510);
    wr("simf.w520", 11'd520);
    wr("simf.w530", 11'd530);
    step("simf.we_re", 1'b1, 1'b1, 11'd400, 4'd4, mkdata(11'd400));
    chk("simf.full_kept", 64'(full), 64'd1);
    step("simf.we_re_lose", 1'b1, 1'b1, 11'd999, 4'd9, mkdata(11'd999));
    for (int i = 0; i < 6; i++) done("simf.drain");

    // Reset mid-operation
    wr("rmid.w1", 11'd123);
    wr("rmid.w2", 11'd45);
    wr("rmid.w3", 11'd678);
    do_reset("rmid.reset");
    chk("rmid.start_tx", 64'(start_tx), 64'd0);

    // Random traffic against the model
    for (int it = 0; it < 800; it++) begin
      int unsigned r = $urandom_range(0, 99);
      if (r == 0) begin
        do_reset("rnd.reset");
      end else begin
        bit w = ($urandom_range(0, 99) < 55);
        bit d = ($urandom_range(0, 99) < 35);
        logic [10:0] id = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 7))
                                                      : 11'($urandom_range(0, 2047));
        logic [63:0] data = {32'($urandom), 32'($urandom)};
        step("rnd", w, d, id, 4'($urandom_range(0, 15)), data);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
